// File: rtl/cpu_boot_pkg.sv
// Shared types and constants for the CPU boot-and-run controller.
package cpu_boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        INIT,
        RUN,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        NONE     = 2'd0,
        HALT     = 2'd1,
        TIMEOUT  = 2'd2,
        OVERFLOW = 2'd3
    } status_t;

    // Instruction memory is byte addressed with one word per instruction.
    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/cpu_boot_ctrl_if.sv
// Bundle of the program stream, memory/register preset, CPU control and status signals.
interface cpu_boot_ctrl_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned WL_W   = 7
);
    logic              start;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic              rf_we;
    logic [REG_AW-1:0] rf_addr;
    logic [DATA_W-1:0] rf_wdata;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_value;
    logic              cpu_run;
    logic [ADDR_W-1:0] pc_in;
    logic              busy;
    logic              done;
    logic [1:0]        status;
    logic [CNT_W-1:0]  cycle_count;
    logic [WL_W-1:0]   words_loaded;

    // Controller side.
    modport master (
        input  start, load_valid, load_data, load_last, pc_in,
        output load_ready, imem_we, imem_addr, imem_wdata, rf_we, rf_addr, rf_wdata,
               pc_load, pc_value, cpu_run, busy, done, status, cycle_count, words_loaded
    );

    // Environment side: program source, memories and CPU.
    modport slave (
        output start, load_valid, load_data, load_last, pc_in,
        input  load_ready, imem_we, imem_addr, imem_wdata, rf_we, rf_addr, rf_wdata,
               pc_load, pc_value, cpu_run, busy, done, status, cycle_count, words_loaded
    );

endinterface

// File: rtl/cpu_run_monitor.sv
// Run-phase watcher: saturating cycle counter, end-of-program compare and timeout compare.
module cpu_run_monitor
    import cpu_boot_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned MAX_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              latch_end,
    input  logic [ADDR_W-1:0] end_addr_in,
    input  logic              run,
    input  logic [ADDR_W-1:0] pc_in,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              halt_hit,
    output logic              timeout_hit
);
    // Timeout fires on the run cycle whose increment brings the count to MAX_CYCLES.
    localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(MAX_CYCLES - 1);

    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] end_q;

    // Counter and latched end address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            end_q <= '0;
        end else begin
            if (latch_end) begin
                end_q <= end_addr_in;
            end
            if (clear) begin
                cnt_q <= '0;
            end else if (run && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign cycle_count = cnt_q;
    assign halt_hit    = run && (pc_in == end_q);
    assign timeout_hit = run && (cnt_q >= LAST_CYCLE);

endmodule

// File: rtl/cpu_boot_ctrl.sv
// Boot-and-run controller: streams a program into instruction memory, presets one register
// and the PC, then runs the CPU until it leaves the program or the cycle limit expires.
module cpu_boot_ctrl
    import cpu_boot_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned BASE_ADDR  = 32'h1000,
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned INIT_REG   = 3,
    parameter int unsigned INIT_VAL   = 32'h4000,
    parameter int unsigned MAX_CYCLES = 100000,
    parameter int unsigned CNT_W      = 32
) (
    input  logic            clk,
    input  logic            rst,
    cpu_boot_ctrl_if.master bus
);
    localparam int unsigned WL_W = $clog2(DEPTH + 1);

    state_t            state_q, state_d;
    status_t           status_q, status_d;
    logic [WL_W-1:0]   wl_q, wl_d;
    logic              last_q, last_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [DATA_W-1:0] imem_wdata_q, imem_wdata_d;

    logic              accept, full, clear, in_init, in_run;
    logic              halt_hit, timeout_hit;
    logic [ADDR_W-1:0] word_addr;
    logic [CNT_W-1:0]  cycle_count;

    // Address of the next word; in INIT this is the first address past the program.
    assign word_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(wl_q) * ADDR_W'(WORD_BYTES);
    assign full      = (wl_q == WL_W'(DEPTH));
    // last_q closes the stream so the final write drains before INIT.
    assign accept    = (state_q == LOAD) && !last_q && bus.load_valid;
    assign clear     = (state_q == IDLE) || ((state_q == DONE) && bus.start);
    assign in_init   = (state_q == INIT);
    assign in_run    = (state_q == RUN);

    // State and load datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            status_q     <= NONE;
            wl_q         <= '0;
            last_q       <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            status_q     <= status_d;
            wl_q         <= wl_d;
            last_q       <= last_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
        end
    end

    // Next-state, status and load-write decisions.
    always_comb begin
        state_d      = state_q;
        status_d     = status_q;
        wl_d         = wl_q;
        last_d       = last_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        if (clear) begin
            status_d = NONE;
            wl_d     = '0;
            last_d   = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = LOAD;
            end
            LOAD: begin
                if (last_q) begin
                    state_d = INIT;
                end else if (accept) begin
                    if (full) begin
                        status_d = OVERFLOW;
                        state_d  = DONE;
                    end else begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = word_addr;
                        imem_wdata_d = bus.load_data;
                        wl_d         = wl_q + WL_W'(1);
                        last_d       = bus.load_last;
                    end
                end
            end
            INIT: state_d = RUN;
            RUN: begin
                if (halt_hit) begin
                    status_d = HALT;
                    state_d  = DONE;
                end else if (timeout_hit) begin
                    status_d = TIMEOUT;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (bus.start) state_d = LOAD;
            end
            default: state_d = IDLE;
        endcase
    end

    cpu_run_monitor #(
        .ADDR_W     (ADDR_W),
        .CNT_W      (CNT_W),
        .MAX_CYCLES (MAX_CYCLES)
    ) u_run_monitor (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .latch_end   (in_init),
        .end_addr_in (word_addr),
        .run         (in_run),
        .pc_in       (bus.pc_in),
        .cycle_count (cycle_count),
        .halt_hit    (halt_hit),
        .timeout_hit (timeout_hit)
    );

    assign bus.load_ready   = (state_q == LOAD) && !last_q;
    assign bus.imem_we      = imem_we_q;
    assign bus.imem_addr    = imem_addr_q;
    assign bus.imem_wdata   = imem_wdata_q;
    // Preset values are gated so every output reads zero outside INIT.
    assign bus.rf_we        = in_init;
    assign bus.rf_addr      = in_init ? REG_AW'(INIT_REG) : '0;
    assign bus.rf_wdata     = in_init ? DATA_W'(INIT_VAL) : '0;
    assign bus.pc_load      = in_init;
    assign bus.pc_value     = in_init ? ADDR_W'(BASE_ADDR) : '0;
    assign bus.cpu_run      = in_run;
    assign bus.busy         = (state_q == LOAD) || in_init || in_run;
    assign bus.done         = (state_q == DONE);
    assign bus.status       = status_q;
    assign bus.cycle_count  = cycle_count;
    assign bus.words_loaded = wl_q;

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Directed bench: a main controller with a small RV32I-subset CPU model attached, and a
// second controller with DEPTH=4 / MAX_CYCLES=50 for the timeout and overflow cases.
module tb_cpu_boot_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_m, rst_s;
    int   tests = 0;
    int   fails = 0;

    cpu_boot_ctrl_if #(.ADDR_W(32), .DATA_W(32), .REG_AW(5), .CNT_W(32), .WL_W(7)) bus_m ();
    cpu_boot_ctrl_if #(.ADDR_W(32), .DATA_W(32), .REG_AW(5), .CNT_W(32), .WL_W(3)) bus_s ();

    cpu_boot_ctrl u_m (.clk(clk), .rst(rst_m), .bus(bus_m));
    cpu_boot_ctrl #(.DEPTH(4), .MAX_CYCLES(50)) u_s (.clk(clk), .rst(rst_s), .bus(bus_s));

    // CPU model on the main controller: ADDI, ADD, SW, BEQ, BNE.
    logic [31:0] cpu_pc = 32'h0;
    logic [31:0] imem_m [0:63];
    logic [31:0] regs [0:31];
    logic [31:0] dmem [0:15];
    logic [31:0] iidx, instr, a, b, imm_i, imm_s, imm_b, daddr;
    logic [4:0]  rd, rs1, rs2;

    assign iidx  = (cpu_pc - 32'h1000) >> 2;
    assign instr = (iidx < 64) ? imem_m[iidx[5:0]] : 32'h13;
    assign rd    = instr[11:7];
    assign rs1   = instr[19:15];
    assign rs2   = instr[24:20];
    assign a     = (rs1 == 5'd0) ? 32'h0 : regs[rs1];
    assign b     = (rs2 == 5'd0) ? 32'h0 : regs[rs2];
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign daddr = a + imm_s - 32'h4000;
    assign bus_m.pc_in = cpu_pc;

    always @(posedge clk) begin
        if (bus_m.imem_we) imem_m[bus_m.imem_addr[7:2]] <= bus_m.imem_wdata;
        if (bus_m.rf_we) regs[bus_m.rf_addr] <= bus_m.rf_wdata;
        if (bus_m.pc_load) begin
            cpu_pc <= bus_m.pc_value;
        end else if (bus_m.cpu_run) begin
            cpu_pc <= cpu_pc + 32'd4;
            case (instr[6:0])
                7'h13: if (rd != 5'd0) regs[rd] <= a + imm_i;
                7'h33: if (rd != 5'd0) regs[rd] <= a + b;
                7'h23: dmem[daddr[5:2]] <= b;
                7'h63: if ((instr[14:12] == 3'b000) == (a == b)) cpu_pc <= cpu_pc + imm_b;
                default: ;
            endcase
        end
    end

    // Event counters sampled away from the active edge.
    int          wr_cnt_m = 0;
    int          wr_cnt_s = 0;
    int          rf_cnt_s = 0;
    int          run_cnt_s = 0;
    logic [31:0] wr_last_s = 32'h0;
    always @(negedge clk) begin
        if (bus_m.imem_we) wr_cnt_m <= wr_cnt_m + 1;
        if (bus_s.imem_we) begin
            wr_cnt_s  <= wr_cnt_s + 1;
            wr_last_s <= bus_s.imem_addr;
        end
        if (bus_s.rf_we) rf_cnt_s <= rf_cnt_s + 1;
        if (bus_s.cpu_run) run_cnt_s <= run_cnt_s + 1;
    end

    function automatic logic [31:0] i_addi(input logic [4:0] d, input logic [4:0] s1,
                                           input logic [11:0] imm);
        return {imm, s1, 3'b000, d, 7'h13};
    endfunction
    function automatic logic [31:0] i_add(input logic [4:0] d, input logic [4:0] s1,
                                          input logic [4:0] s2);
        return {7'b0, s2, s1, 3'b000, d, 7'h33};
    endfunction
    function automatic logic [31:0] i_sw(input logic [4:0] s2, input logic [4:0] s1,
                                         input logic [11:0] imm);
        return {imm[11:5], s2, s1, 3'b010, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] i_br(input logic [2:0] f3, input logic [4:0] s1,
                                         input logic [4:0] s2, input logic [12:0] imm);
        return {imm[12], imm[10:5], s2, s1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_m();
        bus_m.start = 1'b1;
        @(negedge clk);
        bus_m.start = 1'b0;
    endtask

    task automatic start_s();
        bus_s.start = 1'b1;
        @(negedge clk);
        bus_s.start = 1'b0;
    endtask

    // Offer one beat; returns at the negedge after acceptance.
    task automatic push_m(input logic [31:0] w, input logic lst, input logic [31:0] exp_addr);
        int g = 0;
        bus_m.load_valid = 1'b1;
        bus_m.load_data  = w;
        bus_m.load_last  = lst;
        while (bus_m.load_ready !== 1'b1 && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("push_m ready wait", 32'(g < 20), 32'd1);
        @(negedge clk);
        bus_m.load_valid = 1'b0;
        bus_m.load_last  = 1'b0;
        check("imem_we one cycle after accept", 32'(bus_m.imem_we), 32'd1);
        check("imem_addr", bus_m.imem_addr, exp_addr);
        check("imem_wdata", bus_m.imem_wdata, w);
    endtask

    task automatic push_s(input logic [31:0] w, input logic lst);
        int g = 0;
        bus_s.load_valid = 1'b1;
        bus_s.load_data  = w;
        bus_s.load_last  = lst;
        while (bus_s.load_ready !== 1'b1 && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("push_s ready wait", 32'(g < 20), 32'd1);
        @(negedge clk);
        bus_s.load_valid = 1'b0;
        bus_s.load_last  = 1'b0;
    endtask

    task automatic wait_done_m(input int lim);
        int g = 0;
        while (bus_m.done !== 1'b1 && g < lim) begin
            @(negedge clk);
            g++;
        end
        check("main done reached", 32'(bus_m.done), 32'd1);
    endtask

    task automatic wait_done_s(input int lim, output logic prev_run);
        int g = 0;
        prev_run = 1'b0;
        while (bus_s.done !== 1'b1 && g < lim) begin
            prev_run = bus_s.cpu_run;
            @(negedge clk);
            g++;
        end
        check("small done reached", 32'(bus_s.done), 32'd1);
    endtask

    task automatic wait_cnt_m(input logic [31:0] n);
        int g = 0;
        while (bus_m.cycle_count !== n && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("cycle_count reached", bus_m.cycle_count, n);
    endtask

    task automatic check_idle_m(input string tag);
        check({tag, " ctl"}, {25'b0, bus_m.load_ready, bus_m.cpu_run, bus_m.busy, bus_m.done,
                             bus_m.imem_we, bus_m.rf_we, bus_m.pc_load}, 32'h0);
        check({tag, " status"}, 32'(bus_m.status), 32'h0);
        check({tag, " cycle_count"}, bus_m.cycle_count, 32'h0);
        check({tag, " words_loaded"}, 32'(bus_m.words_loaded), 32'h0);
        check({tag, " addr/value"}, bus_m.imem_addr | bus_m.pc_value | bus_m.rf_wdata, 32'h0);
    endtask

    logic [31:0] sum_prog [0:9];
    logic [31:0] beq_self, nop;
    logic        prev_run;
    int          w0, rf0, r0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sum_prog[0] = i_addi(5'd1, 5'd0, 12'd0);
        sum_prog[1] = i_addi(5'd2, 5'd0, 12'd5);
        sum_prog[2] = i_add(5'd1, 5'd1, 5'd2);
        sum_prog[3] = i_addi(5'd2, 5'd2, 12'hfff);
        sum_prog[4] = i_br(3'b001, 5'd2, 5'd0, 13'h1ff8);
        sum_prog[5] = i_sw(5'd1, 5'd3, 12'd0);
        sum_prog[6] = i_addi(5'd4, 5'd0, 12'd7);
        sum_prog[7] = i_add(5'd5, 5'd4, 5'd1);
        sum_prog[8] = i_sw(5'd5, 5'd3, 12'd4);
        sum_prog[9] = i_addi(5'd6, 5'd0, 12'd1);
        beq_self = i_br(3'b000, 5'd0, 5'd0, 13'd0);
        nop      = 32'h0000_0013;

        bus_m.start = 1'b0; bus_m.load_valid = 1'b0; bus_m.load_data = '0; bus_m.load_last = 1'b0;
        bus_s.start = 1'b0; bus_s.load_valid = 1'b0; bus_s.load_data = '0; bus_s.load_last = 1'b0;
        bus_s.pc_in = 32'h1000;
        rst_m = 1'b1;
        rst_s = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_m("reset");
        check("reset small ready/run", {30'b0, bus_s.load_ready, bus_s.cpu_run}, 32'h0);
        rst_m = 1'b0;
        rst_s = 1'b0;
        @(negedge clk);

        // Sum loop: 10 words, halts when the PC reaches 0x1028.
        start_m();
        check("load_ready in LOAD", 32'(bus_m.load_ready), 32'd1);
        check("busy in LOAD", 32'(bus_m.busy), 32'd1);
        for (int i = 0; i < 10; i++) push_m(sum_prog[i], i == 9, 32'h1000 + 32'(4 * i));
        check("ready drops after last", 32'(bus_m.load_ready), 32'd0);
        @(negedge clk);
        check("INIT rf_we/pc_load", {30'b0, bus_m.rf_we, bus_m.pc_load}, 32'h3);
        check("INIT rf_addr", 32'(bus_m.rf_addr), 32'd3);
        check("INIT rf_wdata", bus_m.rf_wdata, 32'h4000);
        check("INIT pc_value", bus_m.pc_value, 32'h1000);
        @(negedge clk);
        check("RUN cpu_run", 32'(bus_m.cpu_run), 32'd1);
        wait_done_m(200);
        check("sum status HALT", 32'(bus_m.status), 32'd1);
        check("sum cycle_count", bus_m.cycle_count, 32'd23);
        check("sum words_loaded", 32'(bus_m.words_loaded), 32'd10);
        check("sum cpu_run off", {30'b0, bus_m.cpu_run, bus_m.busy}, 32'h0);
        repeat (2) @(negedge clk);
        check("dmem[0x4000] sum", dmem[0], 32'd15);
        check("dmem[0x4004]", dmem[1], 32'd22);
        check("sum write count", 32'(wr_cnt_m), 32'd10);

        // Self-loop on the small controller: timeout after 50 cycles.
        r0 = run_cnt_s;
        start_s();
        push_s(beq_self, 1'b1);
        wait_done_s(200, prev_run);
        check("timeout status", 32'(bus_s.status), 32'd2);
        check("timeout cycle_count", bus_s.cycle_count, 32'd50);
        check("timeout words_loaded", 32'(bus_s.words_loaded), 32'd1);
        check("cpu_run falls as done rises", {30'b0, prev_run, bus_s.cpu_run}, 32'h2);
        repeat (3) @(negedge clk);
        check("DONE holds cycle_count", bus_s.cycle_count, 32'd50);
        check("DONE holds status", 32'(bus_s.status), 32'd2);
        check("timeout run cycles", 32'(run_cnt_s - r0), 32'd50);

        // Overflow: DEPTH=4, stream 5 words.
        w0  = wr_cnt_s;
        rf0 = rf_cnt_s;
        r0  = run_cnt_s;
        start_s();
        check("restart clears cycle_count", bus_s.cycle_count, 32'd0);
        check("restart clears status/words", {27'b0, bus_s.status, bus_s.words_loaded}, 32'd0);
        for (int i = 0; i < 5; i++) push_s(32'ha0 + 32'(i), i == 4);
        check("overflow done", 32'(bus_s.done), 32'd1);
        check("overflow status", 32'(bus_s.status), 32'd3);
        check("overflow words_loaded", 32'(bus_s.words_loaded), 32'd4);
        check("overflow ready off", 32'(bus_s.load_ready), 32'd0);
        repeat (3) @(negedge clk);
        check("overflow writes", 32'(wr_cnt_s - w0), 32'd4);
        check("overflow last addr", wr_last_s, 32'h100c);
        check("overflow no rf_we", 32'(rf_cnt_s - rf0), 32'd0);
        check("overflow no cpu_run", 32'(run_cnt_s - r0), 32'd0);

        // Gapped stream with start during LOAD and RUN, then reset mid-RUN.
        w0 = wr_cnt_m;
        start_m();
        check("second run clears counters", bus_m.cycle_count | 32'(bus_m.words_loaded), 32'd0);
        check("second run clears status", 32'(bus_m.status), 32'd0);
        push_m(beq_self, 1'b0, 32'h1000);
        start_m();
        repeat (2) @(negedge clk);
        push_m(nop, 1'b0, 32'h1004);
        repeat (3) @(negedge clk);
        push_m(nop, 1'b1, 32'h1008);
        wait_cnt_m(32'd10);
        start_m();
        wait_cnt_m(32'd20);
        check("gap run busy/cpu_run", {30'b0, bus_m.busy, bus_m.cpu_run}, 32'h3);
        check("gap words_loaded", 32'(bus_m.words_loaded), 32'd3);
        check("gap writes", 32'(wr_cnt_m - w0), 32'd3);
        rst_m = 1'b1;
        #1;
        check_idle_m("mid-run reset");
        @(negedge clk);
        @(negedge clk);
        rst_m = 1'b0;
        @(negedge clk);
        start_m();
        check("reload cycle_count zero", bus_m.cycle_count, 32'd0);
        check("reload ready", 32'(bus_m.load_ready), 32'd1);
        for (int i = 0; i < 10; i++) push_m(sum_prog[i], i == 9, 32'h1000 + 32'(4 * i));
        wait_done_m(200);
        check("reload status HALT", 32'(bus_m.status), 32'd1);
        check("reload cycle_count", bus_m.cycle_count, 32'd23);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_boot_ctrl.md
Name: cpu_boot_ctrl

Overview:
- Synthesizable boot-and-run controller for the single-cycle CPU. Replaces hierarchical memory preloading with a real loading path.
- Accepts a program as a valid/ready word stream and writes it into instruction memory at BASE_ADDR. Presets one register and loads the PC.
- Then runs the CPU, counting cycles until the PC leaves the program (halt) or a cycle limit expires (timeout), and reports status.

Parameters:
- ADDR_W, 32: instruction/PC address width.
- DATA_W, 32: instruction and register word width.
- DEPTH, 64: maximum program length in words.
- BASE_ADDR, 32'h1000: address of the first instruction and initial PC.
- REG_AW, 5: register-file address width.
- INIT_REG, 3: register preset before run.
- INIT_VAL, 32'h4000: value written to INIT_REG.
- MAX_CYCLES, 100000: run-cycle limit.
- CNT_W, 32: cycle counter width; must hold MAX_CYCLES.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a load/run sequence; honoured only in IDLE or DONE.
- load_valid  in  1  program word present.
- load_data  in  DATA_W  program word.
- load_last  in  1  marks final program word.
- load_ready  out  1  controller accepts a word.
- imem_we  out  1  instruction memory write strobe.
- imem_addr  out  ADDR_W  instruction memory write address.
- imem_wdata  out  DATA_W  instruction memory write data.
- rf_we  out  1  register-file preset strobe.
- rf_addr  out  REG_AW  preset register index.
- rf_wdata  out  DATA_W  preset value.
- pc_load  out  1  force the PC.
- pc_value  out  ADDR_W  value forced into the PC.
- cpu_run  out  1  CPU clock enable.
- pc_in  in  ADDR_W  current CPU PC.
- busy  out  1  high in LOAD, INIT and RUN.
- done  out  1  high in DONE.
- status  out  2  result code: 0 NONE, 1 HALT, 2 TIMEOUT, 3 OVERFLOW.
- cycle_count  out  CNT_W  run cycles elapsed.
- words_loaded  out  $clog2(DEPTH+1)  program words written.

Behaviour:
- Reset:
  - State is IDLE.
  - All outputs are 0, including load_ready, cpu_run, status, cycle_count and words_loaded.
  - Reset asserted in any state, including mid-RUN, drops cpu_run and all strobes on the next edge. No partial status is retained.
- IDLE:
  - start moves to LOAD.
  - Clears words_loaded, cycle_count and status.
- LOAD:
  - load_ready is 1.
  - A beat is accepted when load_valid and load_ready are both high.
  - One cycle after acceptance: imem_we=1, imem_addr=BASE_ADDR+4*index, imem_wdata=word. Latency is exactly 1 cycle, registered.
  - words_loaded increments on each accepted beat.
  - load_last accepted, with count ≤ DEPTH, moves to INIT after the final write has issued.
  - A beat accepted when words_loaded==DEPTH is not written; status becomes OVERFLOW and the state moves to DONE.
  - load_valid low holds the state indefinitely.
- INIT, exactly 1 cycle:
  - rf_we=1, rf_addr=INIT_REG, rf_wdata=INIT_VAL.
  - pc_load=1, pc_value=BASE_ADDR.
  - Next state is RUN.
  - end_addr is latched as BASE_ADDR+4*words_loaded, computed modulo 2^ADDR_W.
- RUN:
  - cpu_run=1 and cycle_count increments every cycle.
  - Halt: pc_in==end_addr gives status HALT and moves to DONE.
  - Timeout: cycle_count==MAX_CYCLES with no halt gives status TIMEOUT and moves to DONE.
  - Halt and timeout on the same cycle resolve to HALT.
  - cpu_run deasserts on the cycle DONE is entered.
- DONE:
  - done=1; status, cycle_count and words_loaded hold.
  - start re-enters LOAD, clearing counters on the same edge.
- start outside IDLE/DONE is ignored.
- All arithmetic is unsigned. cycle_count saturates and never wraps.

Decomposition:
- Package cpu_boot_pkg contains:
  - state_t enum: IDLE, LOAD, INIT, RUN, DONE.
  - status_t codes: NONE, HALT, TIMEOUT, OVERFLOW.
  - Constant WORD_BYTES = 4.
- One sub-module, cpu_run_monitor:
  - Holds the cycle counter, end_addr compare and timeout compare.
  - Outputs halt_hit and timeout_hit.
- The FSM and load datapath stay in cpu_boot_ctrl.

Test Plan:
- Sum-loop program, 10 words at 0x1000 with last on word 10, CPU model attached:
  - imem writes go to 0x1000..0x1024.
  - rf write sets r3=0x4000; pc_load with 0x1000.
  - status=HALT when the PC reaches 0x1028; data memory 0x4000 holds the final sum.
- Self-loop program (a branch to itself) with MAX_CYCLES=50:
  - status=TIMEOUT, cycle_count=50, cpu_run falls on the same edge done rises.
- DEPTH=4, stream 5 words:
  - 4 writes issued, the 5th not written.
  - status=OVERFLOW, words_loaded=4, no rf_we, no cpu_run.
- load_valid gaps of 3 idle cycles between beats:
  - No spurious imem_we; addresses remain contiguous 0x1000, 0x1004, 0x1008.
- rst pulsed mid-RUN at cycle 20:
  - cpu_run=0 and all outputs 0 immediately.
  - A following start reloads cleanly with cycle_count restarting at 0.
- start asserted during LOAD and during RUN:
  - Ignored; the sequence completes normally.
  - start in DONE starts a second run with counters cleared.
